hazard_stall_controller: RTL and testbench

- Control-side counterpart of the pipeline registers. It generates the write-enable, flush and bubble controls that the IF/ID and ID/EX registers consume.
- Detects load-use hazards, taken branches (resolved in EX), jumps (resolved in ID), data-memory wait states and interrupt entry.
- Sequences multi-cycle stalls and pipeline drains with a small FSM and a drain counter.
- Sits beside the ID stage; its outputs drive PC, IF_ID_Register and the ID/EX control-zeroing mux.

---
 rtl/hazard_stall_controller_pkg.sv | 35 +++
 rtl/hazard_stall_controller_if.sv | 34 +++
 rtl/hazard_stall_controller_compare.sv | 17 +
 rtl/hazard_stall_controller.sv | 121 ++++++++++++
 tb/tb_hazard_stall_controller.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_controller_pkg.sv
// Shared types for the hazard/stall controller: FSM encoding and the
// pipeline control word it drives.
package hazard_stall_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MEM_WAIT  = 2'd1,
        ST_IRQ_DRAIN = 2'd2,
        ST_IRQ_ACK   = 2'd3
    } state_t;

    // MSB first: {pc_write, if_id_write, if_flush, id_ex_bubble, ex_mem_hold, irq_ack}
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_flush;
        logic id_ex_bubble;
        logic ex_mem_hold;
        logic irq_ack;
    } ctrl_t;

    localparam int CTRL_W          = $bits(ctrl_t);
    localparam int CTRL_BUBBLE_BIT = 2;

    localparam ctrl_t CTRL_IDLE     = 6'b000000;
    localparam ctrl_t CTRL_RESET    = 6'b000100;
    localparam ctrl_t CTRL_FREEZE   = 6'b000010;
    localparam ctrl_t CTRL_BRANCH   = 6'b101100;
    localparam ctrl_t CTRL_LOAD_USE = 6'b000100;
    localparam ctrl_t CTRL_JUMP     = 6'b111000;
    localparam ctrl_t CTRL_DRAIN    = 6'b001100;
    localparam ctrl_t CTRL_ACK      = 6'b101101;
    localparam ctrl_t CTRL_NORMAL   = 6'b110000;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side signal bundle of the hazard/stall controller.
// All signals are level-sensitive and sampled every cycle; there is no valid/ready handshake.
interface hazard_stall_controller_if #(parameter int CNT_W = 16);
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_UsesRt;
    logic             EX_MemRead;
    logic [4:0]       EX_Rt;
    logic             ID_Jump;
    logic             EX_BranchTaken;
    logic             mem_busy;
    logic             irq_req;
    logic             PC_Write;
    logic             IF_ID_Write;
    logic             IF_Flush;
    logic             ID_EX_Bubble;
    logic             EX_MEM_Hold;
    logic             irq_ack;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_Rt, ID_Jump,
               EX_BranchTaken, mem_busy, irq_req,
        input  PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, EX_MEM_Hold,
               irq_ack, stall_cnt
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_Rt, ID_Jump,
               EX_BranchTaken, mem_busy, irq_req,
        output PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, EX_MEM_Hold,
               irq_ack, stall_cnt
    );
endinterface

// File: rtl/hazard_stall_controller_compare.sv
// Load-use comparator; kept standalone so a forwarding unit can reuse it.
module hazard_compare (
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       load_use
);
    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = (ex_rt == id_rs);
    assign rt_hit   = id_uses_rt && (ex_rt == id_rt);
    // r0 is hardwired to zero, so a load targeting it never creates a dependency
    assign load_use = ex_mem_read && (ex_rt != 5'd0) && (rs_hit || rt_hit);
endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/flush/bubble generator for the IF/ID and ID/EX registers, with
// memory-wait freeze and interrupt drain sequencing.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic                      sysclk,
    input  logic                      reset,
    hazard_stall_controller_if.slave  bus,
    output state_t                    dbg_state
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_t           state_q, state_d;
    state_t           resume_q, resume_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] stall_cnt_q;
    ctrl_t            ctrl;
    logic             load_use;
    logic             run_eval;

    hazard_compare u_hazard_compare (
        .id_rs       (bus.ID_Rs),
        .id_rt       (bus.ID_Rt),
        .id_uses_rt  (bus.ID_UsesRt),
        .ex_mem_read (bus.EX_MemRead),
        .ex_rt       (bus.EX_Rt),
        .load_use    (load_use)
    );

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            resume_q    <= ST_RUN;
            drain_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            drain_q  <= drain_d;
            if (!ctrl.pc_write && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        ctrl     = CTRL_IDLE;
        state_d  = state_q;
        resume_d = resume_q;
        drain_d  = drain_q;
        run_eval = 1'b0;

        case (state_q)
            ST_RUN: run_eval = 1'b1;
            ST_MEM_WAIT: begin
                // The cycle memory becomes ready is already a normal RUN cycle
                if (bus.mem_busy)              ctrl = CTRL_FREEZE;
                else if (resume_q == ST_RUN)   run_eval = 1'b1;
                else                           state_d = resume_q;
            end
            ST_IRQ_DRAIN: begin
                ctrl = CTRL_DRAIN;
                if (bus.mem_busy) begin
                    ctrl.ex_mem_hold = 1'b1;
                end else if (drain_q <= DW'(1)) begin
                    state_d = ST_IRQ_ACK;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            ST_IRQ_ACK: begin
                if (bus.mem_busy) begin
                    ctrl             = CTRL_DRAIN;
                    ctrl.ex_mem_hold = 1'b1;
                end else begin
                    ctrl    = CTRL_ACK;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (run_eval) begin
            state_d = ST_RUN;
            if (bus.mem_busy) begin
                ctrl     = CTRL_FREEZE;
                state_d  = ST_MEM_WAIT;
                resume_d = ST_RUN;
            end else if (bus.EX_BranchTaken) begin
                // The ID instruction is wrong-path, so its load-use is moot
                ctrl = CTRL_BRANCH;
            end else if (load_use) begin
                ctrl = CTRL_LOAD_USE;
            end else if (bus.ID_Jump) begin
                ctrl = CTRL_JUMP;
            end else if (bus.irq_req) begin
                // This cycle is the first flush cycle of the drain
                ctrl    = CTRL_DRAIN;
                drain_d = DW'(DRAIN_CYCLES - 1);
                state_d = (DRAIN_CYCLES > 1) ? ST_IRQ_DRAIN : ST_IRQ_ACK;
            end else begin
                ctrl = CTRL_NORMAL;
            end
        end

        if (!reset) ctrl = CTRL_RESET;
    end

    assign bus.PC_Write     = ctrl.pc_write;
    assign bus.IF_ID_Write  = ctrl.if_id_write;
    assign bus.IF_Flush     = ctrl.if_flush;
    assign bus.ID_EX_Bubble = ctrl.id_ex_bubble;
    assign bus.EX_MEM_Hold  = ctrl.ex_mem_hold;
    assign bus.irq_ack      = ctrl.irq_ack;
    assign bus.stall_cnt    = stall_cnt_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed table, corner
// sequences and randomized cycles against a cycle-count reference model.
module tb_hazard_stall_controller;
    import hazard_stall_controller_pkg::*;

    localparam int DRAIN   = 3;
    localparam int CW      = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    // control vector bit order: {pc, if_id, flush, bubble, hold, ack}
    localparam logic [5:0] E_RESET  = 6'b000100;
    localparam logic [5:0] E_NORMAL = 6'b110000;
    localparam logic [5:0] E_LU     = 6'b000100;
    localparam logic [5:0] E_BR     = 6'b101100;
    localparam logic [5:0] E_JUMP   = 6'b111000;
    localparam logic [5:0] E_FREEZE = 6'b000010;
    localparam logic [5:0] E_FLUSH  = 6'b001100;
    localparam logic [5:0] E_FL_HLD = 6'b001110;
    localparam logic [5:0] E_ACK    = 6'b101101;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mem_read;
        logic [4:0] ex_rt;
        logic       jump;
        logic       br;
        logic       busy;
        logic       irq;
    } in_t;

    typedef struct {
        in_t        in;
        logic [5:0] exp;
        string      name;
    } vec_t;

    logic   sysclk;
    logic   reset;
    state_t dbg_state;
    logic [5:0] got_ctrl;

    int errors = 0;
    int checks = 0;

    // reference model: remaining drain cycles (-1 = no interrupt in progress)
    int m_irq_left;
    int m_cnt;

    hazard_stall_controller_if #(.CNT_W(CW)) bus ();

    hazard_stall_controller #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    assign got_ctrl = {bus.PC_Write, bus.IF_ID_Write, bus.IF_Flush,
                       bus.ID_EX_Bubble, bus.EX_MEM_Hold, bus.irq_ack};

    // clock / reset
    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic in_t mk(input int rs, input int rt, input int uses, input int mr,
                               input int exrt, input int j, input int br, input int busy,
                               input int irq);
        in_t r;
        r.rs = 5'(rs); r.rt = 5'(rt); r.uses_rt = 1'(uses); r.mem_read = 1'(mr);
        r.ex_rt = 5'(exrt); r.jump = 1'(j); r.br = 1'(br); r.busy = 1'(busy); r.irq = 1'(irq);
        return r;
    endfunction

    function automatic bit model_hazard(input in_t i);
        return i.mem_read && (i.ex_rt != 0) &&
               ((i.ex_rt == i.rs) || (i.uses_rt && (i.ex_rt == i.rt)));
    endfunction

    function automatic logic [5:0] model_out(input in_t i);
        if (m_irq_left > 0)  return i.busy ? E_FL_HLD : E_FLUSH;
        if (m_irq_left == 0) return i.busy ? E_FL_HLD : E_ACK;
        if (i.busy)              return E_FREEZE;
        if (i.br)                return E_BR;
        if (model_hazard(i))     return E_LU;
        if (i.jump)              return E_JUMP;
        if (i.irq)               return E_FLUSH;
        return E_NORMAL;
    endfunction

    task automatic model_step(input in_t i);
        logic [5:0] o;
        o = model_out(i);
        if (!o[5] && m_cnt < CNT_MAX) m_cnt++;
        if (m_irq_left > 0) begin
            if (!i.busy) m_irq_left--;
        end else if (m_irq_left == 0) begin
            if (!i.busy) m_irq_left = -1;
        end else if (!i.busy && !i.br && !model_hazard(i) && !i.jump && i.irq) begin
            m_irq_left = DRAIN - 1;
        end
    endtask

    task automatic model_reset();
        m_irq_left = -1;
        m_cnt      = 0;
    endtask

    // driver tasks
    task automatic apply(input in_t i);
        bus.ID_Rs = i.rs; bus.ID_Rt = i.rt; bus.ID_UsesRt = i.uses_rt;
        bus.EX_MemRead = i.mem_read; bus.EX_Rt = i.ex_rt; bus.ID_Jump = i.jump;
        bus.EX_BranchTaken = i.br; bus.mem_busy = i.busy; bus.irq_req = i.irq;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // one clock: drive at negedge, check Mealy outputs 1ns later, model follows the posedge
    task automatic run_cycle(input in_t i, input string name, input int want);
        logic [5:0] e;
        @(negedge sysclk);
        apply(i);
        #1;
        e = model_out(i);
        check({name, " ctrl"}, 32'(got_ctrl), 32'(e));
        check({name, " cnt"}, 32'(bus.stall_cnt), 32'(m_cnt));
        if (want >= 0) check({name, " fixed"}, 32'(got_ctrl), 32'(want));
        model_step(i);
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        #1;
        check("reset ctrl", 32'(got_ctrl), 32'(E_RESET));
        check("reset cnt", 32'(bus.stall_cnt), 32'd0);
        check("reset state", 32'(dbg_state), 32'(ST_RUN));
        @(negedge sysclk);
        reset = 1'b1;
        model_reset();
    endtask

    vec_t tbl[10];
    in_t  idle;
    in_t  r;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        apply(idle);
        model_reset();

        tbl[0] = '{mk(3, 4, 1, 0, 0, 0, 0, 0, 0), E_NORMAL, "idle"};
        tbl[1] = '{mk(8, 2, 0, 1, 8, 0, 0, 0, 0), E_LU,     "lu_rs"};
        tbl[2] = '{mk(0, 0, 1, 1, 0, 0, 0, 0, 0), E_NORMAL, "lu_r0"};
        tbl[3] = '{mk(1, 9, 1, 1, 9, 0, 0, 0, 0), E_LU,     "lu_rt"};
        tbl[4] = '{mk(1, 9, 0, 1, 9, 0, 0, 0, 0), E_NORMAL, "rt_unused"};
        tbl[5] = '{mk(8, 2, 0, 1, 8, 0, 1, 0, 0), E_BR,     "br_lu"};
        tbl[6] = '{mk(5, 6, 1, 0, 0, 1, 0, 0, 0), E_JUMP,   "jump"};
        tbl[7] = '{mk(7, 6, 1, 1, 7, 1, 0, 0, 0), E_LU,     "jump_lu"};
        tbl[8] = '{mk(5, 6, 1, 0, 0, 1, 1, 0, 0), E_BR,     "br_jump"};
        tbl[9] = '{mk(8, 8, 1, 0, 8, 0, 0, 0, 0), E_NORMAL, "no_load"};

        do_reset();
        for (int k = 0; k < 10; k++) run_cycle(tbl[k].in, tbl[k].name, int'(tbl[k].exp));

        // load-use: exactly one stall cycle, then normal
        do_reset();
        run_cycle(mk(8, 0, 0, 1, 8, 0, 0, 0, 0), "seq_lu", int'(E_LU));
        run_cycle(idle, "seq_lu_after", int'(E_NORMAL));
        check("seq_lu stall_cnt", 32'(bus.stall_cnt), 32'd1);

        // clean interrupt entry: three flush cycles, ack on the fourth
        do_reset();
        for (int k = 0; k < DRAIN; k++)
            run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "irq_drain", int'(E_FLUSH));
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "irq_ack", int'(E_ACK));
        run_cycle(idle, "irq_done", int'(E_NORMAL));

        // interrupt with two memory-wait cycles mid-drain: ack two cycles later
        do_reset();
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "irqb_0", int'(E_FLUSH));
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), "irqb_1", int'(E_FL_HLD));
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), "irqb_2", int'(E_FL_HLD));
        run_cycle(idle, "irqb_3", int'(E_FLUSH));
        run_cycle(idle, "irqb_4", int'(E_FLUSH));
        run_cycle(idle, "irqb_5", int'(E_ACK));
        run_cycle(idle, "irqb_6", int'(E_NORMAL));

        // delayed ack: memory busy during the ack cycle
        do_reset();
        for (int k = 0; k < DRAIN; k++)
            run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "irqa_drain", int'(E_FLUSH));
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), "irqa_held", int'(E_FL_HLD));
        run_cycle(idle, "irqa_ack", int'(E_ACK));

        // memory wait for five cycles, normal in the cycle busy falls
        do_reset();
        for (int k = 0; k < 5; k++)
            run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), "mw_busy", int'(E_FREEZE));
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "mw_resume", int'(E_NORMAL));
        check("mw stall_cnt", 32'(bus.stall_cnt), 32'd5);

        // asynchronous reset in the middle of a drain aborts without an ack
        do_reset();
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), "rst_irq", int'(E_FLUSH));
        run_cycle(idle, "rst_drain", int'(E_FLUSH));
        @(negedge sysclk);
        apply(idle);
        #2;
        reset = 1'b0;
        #1;
        check("async reset ctrl", 32'(got_ctrl), 32'(E_RESET));
        check("async reset state", 32'(dbg_state), 32'(ST_RUN));
        check("async reset cnt", 32'(bus.stall_cnt), 32'd0);
        @(negedge sysclk);
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < 6; k++) run_cycle(idle, "post_abort", int'(E_NORMAL));

        // stall counter saturation
        do_reset();
        @(negedge sysclk);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        repeat ((1 << CW) + 3) @(posedge sysclk);
        @(negedge sysclk);
        #1;
        check("sat stall_cnt", 32'(bus.stall_cnt), 32'(CNT_MAX));
        m_cnt = CNT_MAX;
        run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), "sat_hold", int'(E_FREEZE));
        check("sat no wrap", 32'(bus.stall_cnt), 32'(CNT_MAX));

        // randomized cycles against the model
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            r.rs       = 5'($urandom_range(0, 3));
            r.rt       = 5'($urandom_range(0, 3));
            r.uses_rt  = 1'($urandom_range(0, 1));
            r.mem_read = 1'($urandom_range(0, 1));
            r.ex_rt    = 5'($urandom_range(0, 3));
            r.jump     = ($urandom_range(0, 5) == 0);
            r.br       = ($urandom_range(0, 5) == 0);
            r.busy     = ($urandom_range(0, 7) == 0);
            r.irq      = ($urandom_range(0, 9) == 0);
            run_cycle(r, "rnd", -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
